// File: rtl/i2c_byte_master.sv
// rtl/i2c_byte_master.sv - byte-level I2C master driving open-drain SDA/SCL pads
// Runs START/WRITE/READ/STOP commands in quarter-SCL steps and returns one response per command.
module i2c_byte_master #(
  parameter int CLK_DIV = 30
) (
  input  logic       io_mainClk,
  input  logic       resetCtrl_systemReset,
  input  logic       io_cmd_valid,
  output logic       io_cmd_ready,
  input  logic [1:0] io_cmd_kind,
  input  logic [7:0] io_cmd_data,
  input  logic       io_cmd_ackOut,
  output logic       io_rsp_valid,
  input  logic       io_rsp_ready,
  output logic [7:0] io_rsp_data,
  output logic       io_rsp_ack,
  output logic       io_rsp_error,
  output logic       io_busActive,
  input  logic       io_i2c_sda_read,
  output logic       io_i2c_sda_write,
  input  logic       io_i2c_scl_read,
  output logic       io_i2c_scl_write
);

  localparam int               CNT_W    = $clog2(CLK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  localparam logic [1:0] K_START = 2'd0;
  localparam logic [1:0] K_WRITE = 2'd1;
  localparam logic [1:0] K_READ  = 2'd2;
  localparam logic [1:0] K_STOP  = 2'd3;

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_STOP, S_RSP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;
  logic [3:0]       bit_q, bit_d;
  logic [1:0]       kind_q;
  logic [7:0]       data_q;
  logic             ack_out_q;
  logic             busy_q, busy_d;
  logic             ready_q;
  logic             sda_q, sda_d;
  logic             scl_q, scl_d;
  logic [7:0]       rsp_data_q, rsp_data_d;
  logic             rsp_ack_q, rsp_ack_d;
  logic             rsp_error_q, rsp_error_d;

  logic       accept, legal, in_quarter, stall, qtr_end, sample;
  logic [1:0] cur_kind;
  logic [7:0] cur_data;
  logic       cur_ack_out;
  logic       tx_bit;

  assign accept     = io_cmd_valid && ready_q;
  assign legal      = (io_cmd_kind == K_START) || busy_q;
  assign in_quarter = (state_q == S_START) || (state_q == S_BIT) || (state_q == S_STOP);
  // A released SCL still read low means the slave is stretching: freeze the quarter.
  assign stall      = scl_q && !io_i2c_scl_read;
  assign qtr_end    = in_quarter && !stall && (cnt_q == CNT_LAST);
  assign sample     = (state_q == S_BIT) && (qtr_q == 2'd2) && qtr_end;

  always_ff @(posedge io_mainClk) begin
    if (resetCtrl_systemReset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      qtr_q       <= '0;
      bit_q       <= '0;
      kind_q      <= '0;
      data_q      <= '0;
      ack_out_q   <= 1'b0;
      busy_q      <= 1'b0;
      ready_q     <= 1'b0;
      sda_q       <= 1'b1;
      scl_q       <= 1'b1;
      rsp_data_q  <= '0;
      rsp_ack_q   <= 1'b0;
      rsp_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      qtr_q       <= qtr_d;
      bit_q       <= bit_d;
      kind_q      <= cur_kind;
      data_q      <= cur_data;
      ack_out_q   <= cur_ack_out;
      busy_q      <= busy_d;
      ready_q     <= (state_d == S_IDLE);
      sda_q       <= sda_d;
      scl_q       <= scl_d;
      rsp_data_q  <= rsp_data_d;
      rsp_ack_q   <= rsp_ack_d;
      rsp_error_q <= rsp_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    qtr_d       = qtr_q;
    bit_d       = bit_q;
    busy_d      = busy_q;
    rsp_data_d  = rsp_data_q;
    rsp_ack_d   = rsp_ack_q;
    rsp_error_d = rsp_error_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d       = '0;
          qtr_d       = '0;
          bit_d       = '0;
          rsp_data_d  = '0;
          rsp_ack_d   = 1'b0;
          rsp_error_d = !legal;
          if (!legal) begin
            state_d = S_RSP;
          end else begin
            case (io_cmd_kind)
              K_START: state_d = S_START;
              K_STOP:  state_d = S_STOP;
              default: state_d = S_BIT;
            endcase
          end
        end
      end
      S_START, S_BIT, S_STOP: begin
        if (!stall) begin
          if (cnt_q != CNT_LAST) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cnt_d = '0;
            qtr_d = qtr_q + 2'd1;
            if (qtr_q == 2'd3) begin
              if ((state_q == S_BIT) && (bit_q != 4'd8)) begin
                bit_d = bit_q + 4'd1;
              end else begin
                state_d = S_RSP;
              end
              if (state_q == S_START) busy_d = 1'b1;
              if (state_q == S_STOP)  busy_d = 1'b0;
            end
          end
        end
      end
      S_RSP: begin
        if (io_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (sample) begin
      if (bit_q == 4'd8) begin
        rsp_ack_d = (kind_q == K_WRITE) ? io_i2c_sda_read : ack_out_q;
      end else if (kind_q == K_READ) begin
        rsp_data_d = {rsp_data_q[6:0], io_i2c_sda_read};
      end
    end
  end

  // Line levels are a function of the upcoming quarter; the accept cycle sees the raw command.
  always_comb begin
    cur_kind    = accept ? io_cmd_kind   : kind_q;
    cur_data    = accept ? io_cmd_data   : data_q;
    cur_ack_out = accept ? io_cmd_ackOut : ack_out_q;
    if (bit_d == 4'd8) begin
      tx_bit = (cur_kind == K_WRITE) ? 1'b1 : cur_ack_out;
    end else begin
      tx_bit = (cur_kind == K_WRITE) ? cur_data[~bit_d[2:0]] : 1'b1;
    end
    sda_d = sda_q;
    scl_d = scl_q;
    case (state_d)
      S_START: begin
        case (qtr_d)
          2'd0:    sda_d = 1'b1;
          2'd1:    scl_d = 1'b1;
          2'd2:    sda_d = 1'b0;
          default: scl_d = 1'b0;
        endcase
      end
      S_BIT: begin
        case (qtr_d)
          2'd0: begin
            scl_d = 1'b0;
            sda_d = tx_bit;
          end
          2'd2:    scl_d = 1'b1;
          default: ;
        endcase
      end
      S_STOP: begin
        case (qtr_d)
          2'd0: begin
            scl_d = 1'b0;
            sda_d = 1'b0;
          end
          2'd1:    scl_d = 1'b1;
          2'd2:    sda_d = 1'b1;
          default: ;
        endcase
      end
      S_RSP: begin
        if (state_q == S_BIT) begin
          scl_d = 1'b0;
          sda_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign io_cmd_ready     = ready_q;
  assign io_rsp_valid     = (state_q == S_RSP);
  assign io_rsp_data      = rsp_data_q;
  assign io_rsp_ack       = rsp_ack_q;
  assign io_rsp_error     = rsp_error_q;
  assign io_busActive     = busy_q;
  assign io_i2c_sda_write = sda_q;
  assign io_i2c_scl_write = scl_q;

endmodule

// File: tb/tb_i2c_byte_master.sv
// tb/tb_i2c_byte_master.sv - randomized self-checking bench for i2c_byte_master
// A bench-side slave model drives the open-drain bus; expectations come from command-level rules.
module tb_i2c_byte_master;

  localparam int CD = 4;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_kind;
  logic [7:0] cmd_data;
  logic       cmd_ack_out;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_ack;
  logic       rsp_error;
  logic       bus_active;
  logic       sda_w, scl_w;
  logic       slave_sda = 1'b1;
  logic       slave_scl = 1'b1;
  logic       sda_bus, scl_bus;

  assign sda_bus = sda_w & slave_sda;
  assign scl_bus = scl_w & slave_scl;

  i2c_byte_master #(.CLK_DIV(CD)) dut (
    .io_mainClk            (clk),
    .resetCtrl_systemReset (rst),
    .io_cmd_valid          (cmd_valid),
    .io_cmd_ready          (cmd_ready),
    .io_cmd_kind           (cmd_kind),
    .io_cmd_data           (cmd_data),
    .io_cmd_ackOut         (cmd_ack_out),
    .io_rsp_valid          (rsp_valid),
    .io_rsp_ready          (rsp_ready),
    .io_rsp_data           (rsp_data),
    .io_rsp_ack            (rsp_ack),
    .io_rsp_error          (rsp_error),
    .io_busActive          (bus_active),
    .io_i2c_sda_read       (sda_bus),
    .io_i2c_sda_write      (sda_w),
    .io_i2c_scl_read       (scl_bus),
    .io_i2c_scl_write      (scl_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave configuration, written only by the stimulus process.
  int         cfg_mode = 0;
  logic [7:0] cfg_byte = 8'h00;
  logic       cfg_ack  = 1'b1;
  int         cfg_sbit = -1;
  int         cfg_sn   = 0;
  int         cmd_seq  = 0;

  // Slave/monitor state, written only by the monitor process.
  int   fcnt = 0, seen_seq = 0, viol = 0, stretch_left = 0;
  bit   stretch_done = 1'b0;
  logic prev_scl = 1'b1, prev_sda = 1'b1, cur_scl, cur_sda;
  logic samp[$];

  always @(negedge clk) begin
    if (stretch_left > 0) begin
      stretch_left--;
      if (stretch_left == 0) slave_scl = 1'b1;
    end else if (cfg_mode != 0 && !stretch_done && fcnt == cfg_sbit && scl_w) begin
      slave_scl    = 1'b0;
      stretch_left = cfg_sn;
      stretch_done = 1'b1;
    end
    cur_scl = scl_w & slave_scl;
    cur_sda = sda_w & slave_sda;
    if (seen_seq != cmd_seq) begin
      seen_seq     = cmd_seq;
      fcnt         = 0;
      stretch_done = 1'b0;
      samp.delete();
    end else begin
      if (prev_scl && !cur_scl) fcnt++;
      if (!prev_scl && cur_scl) samp.push_back(cur_sda);
      if (cfg_mode != 0 && prev_scl && cur_scl && prev_sda != cur_sda) viol++;
    end
    case (cfg_mode)
      1:       slave_sda = (fcnt == 8) ? cfg_ack : 1'b1;
      2:       slave_sda = (fcnt < 8) ? cfg_byte[7-fcnt] : 1'b1;
      default: slave_sda = 1'b1;
    endcase
    prev_scl = scl_w & slave_scl;
    prev_sda = sda_w & slave_sda;
  end

  int   total = 0;
  int   bad   = 0;
  logic model_busy = 1'b0;
  int   last_sda_fall, last_sda_rise, last_scl_fall;
  logic last_fall_scl, last_rise_scl;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_cmd(input logic [1:0] k, input logic [7:0] d, input logic ao,
                        input logic sack, input int sbit, input int sn, input int hold);
    int   lat, exp_lat, n;
    logic legal, exp_ack, ps, pc, changed, eb;
    logic [7:0] exp_data;
    legal    = (k == 2'd0) || model_busy;
    cfg_mode = (legal && k == 2'd1) ? 1 : (legal && k == 2'd2) ? 2 : 0;
    cfg_byte = d;
    cfg_ack  = sack;
    cfg_sbit = (cfg_mode != 0 && sn > 0) ? sbit : -1;
    cfg_sn   = sn;
    cmd_seq++;
    if (!legal)                       exp_lat = 1;
    else if (k == 2'd0 || k == 2'd3)  exp_lat = 4 * CD + 1;
    else                              exp_lat = 36 * CD + 1 + ((cfg_sbit >= 0) ? sn : 0);
    exp_data = (legal && k == 2'd2) ? d : 8'h00;
    exp_ack  = !legal ? 1'b0 : (k == 2'd1) ? sack : (k == 2'd2) ? ao : 1'b0;

    cmd_kind = k; cmd_data = d; cmd_ack_out = ao; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    ps = sda_w; pc = scl_w; changed = 1'b0; lat = 0;
    last_sda_fall = -1; last_sda_rise = -1; last_scl_fall = -1;
    last_fall_scl = 1'b0; last_rise_scl = 1'b0;
    do begin
      @(negedge clk);
      lat++;
      cmd_valid = 1'b0;
      if (sda_w != ps) begin
        changed = 1'b1;
        if (sda_w) begin last_sda_rise = lat; last_rise_scl = scl_w; end
        else       begin last_sda_fall = lat; last_fall_scl = scl_w; end
      end
      if (scl_w != pc) begin
        changed = 1'b1;
        if (!scl_w) last_scl_fall = lat;
      end
      ps = sda_w; pc = scl_w;
    end while (!rsp_valid && lat < 1000);
    chk("latency", lat, exp_lat);
    if (!rsp_valid) return;
    chk("rsp_error", int'(rsp_error), int'(!legal));
    chk("rsp_data", int'(rsp_data), int'(exp_data));
    chk("rsp_ack", int'(rsp_ack), int'(exp_ack));
    if (!legal) chk("illegal_line_activity", int'(changed), 0);
    if (cfg_mode != 0) begin
      chk("scl_rises", samp.size(), 9);
      if (samp.size() == 9) begin
        for (int i = 0; i < 9; i++) begin
          eb = (i < 8) ? d[7-i] : ((k == 2'd1) ? sack : ao);
          chk($sformatf("sda_bit%0d", i), int'(samp[i]), int'(eb));
        end
      end
    end
    for (int i = 0; i < hold; i++) @(negedge clk);
    chk("rsp_hold_valid", int'(rsp_valid), 1);
    chk("rsp_hold_data", int'(rsp_data), int'(exp_data));
    chk("rsp_hold_ack", int'(rsp_ack), int'(exp_ack));
    if (legal && k == 2'd0) model_busy = 1'b1;
    if (legal && k == 2'd3) model_busy = 1'b0;
    chk("bus_active", int'(bus_active), int'(model_busy));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("ready_after_rsp", int'(cmd_ready), 1);
    chk("rsp_dropped", int'(rsp_valid), 0);
  endtask

  initial begin
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_kind = 2'd0; cmd_data = 8'h00;
    cmd_ack_out = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_sda", int'(sda_w), 1);
    chk("reset_scl", int'(scl_w), 1);
    chk("reset_cmd_ready", int'(cmd_ready), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    chk("reset_rsp_data", int'(rsp_data), 0);
    chk("reset_rsp_ack", int'(rsp_ack), 0);
    chk("reset_rsp_error", int'(rsp_error), 0);
    chk("reset_bus_active", int'(bus_active), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(cmd_ready), 1);

    do_cmd(2'd0, 8'h00, 1'b0, 1'b1, -1, 0, 0);
    chk("start_sda_fall_cycle", last_sda_fall, 2 * CD + 1);
    chk("start_sda_fall_scl_high", int'(last_fall_scl), 1);
    chk("start_scl_fall_cycle", last_scl_fall, 3 * CD + 1);

    do_cmd(2'd1, 8'hA5, 1'b0, 1'b0, -1, 0, 2);
    do_cmd(2'd2, 8'h3C, 1'b1, 1'b1, -1, 0, 0);
    do_cmd(2'd3, 8'h00, 1'b0, 1'b1, -1, 0, 0);
    chk("stop_sda_rise_cycle", last_sda_rise, 2 * CD + 1);
    chk("stop_sda_rise_scl_high", int'(last_rise_scl), 1);

    do_cmd(2'd1, 8'h55, 1'b0, 1'b0, -1, 0, 1);

    do_cmd(2'd0, 8'h00, 1'b0, 1'b1, -1, 0, 0);
    do_cmd(2'd1, 8'hC3, 1'b0, 1'b0, 3, 10, 0);
    do_cmd(2'd3, 8'h00, 1'b0, 1'b1, -1, 0, 0);

    for (int it = 0; it < 30; it++) begin
      do_cmd(2'($urandom_range(0, 3)), 8'($urandom), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 8)) : -1,
             int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
    end
    chk("sda_stable_while_scl_high", viol, 0);

    if (!model_busy) do_cmd(2'd0, 8'h00, 1'b0, 1'b1, -1, 0, 0);
    cfg_mode = 2; cfg_byte = 8'h96; cfg_sbit = -1; cmd_seq++;
    cmd_kind = 2'd2; cmd_data = 8'h00; cmd_ack_out = 1'b0; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reset_test_accept", int'(cmd_ready), 1);
    repeat (1 + 16 * 5 + 6) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk("midop_reset_sda", int'(sda_w), 1);
    chk("midop_reset_scl", int'(scl_w), 1);
    chk("midop_reset_rsp_valid", int'(rsp_valid), 0);
    chk("midop_reset_bus_active", int'(bus_active), 0);
    chk("midop_reset_cmd_ready", int'(cmd_ready), 0);
    rst = 1'b0;
    model_busy = 1'b0;
    cfg_mode = 0; cmd_seq++;
    @(negedge clk);
    chk("midop_ready_after_release", int'(cmd_ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
